// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: serializes whole-burst read/write transactions from two
// requesters onto one burst RAM command port, streaming write words and routing read words.
// Ports: clk, rst_n (sync, active-low); pN_req/cmd/addr/wr_data from requester N;
// pN_grant/wr_next/rd_valid/done to requester N; rd_data shared read word;
// br_* RAM command/data side; br_busy holds off new commands.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// (fixed priority, port 0 wins, when undefined).
module burst_ram_arbiter #(
  parameter int ADDR_BITWIDTH = 4,
  parameter int DATA_BITWIDTH = 64,
  parameter int BURST_COUNT   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       p0_req,
  input  logic                       p1_req,
  input  logic                       p0_cmd,
  input  logic                       p1_cmd,
  input  logic [ADDR_BITWIDTH-1:0]   p0_addr,
  input  logic [ADDR_BITWIDTH-1:0]   p1_addr,
  input  logic [DATA_BITWIDTH-1:0]   p0_wr_data,
  input  logic [DATA_BITWIDTH-1:0]   p1_wr_data,
  output logic                       p0_grant,
  output logic                       p1_grant,
  output logic                       p0_wr_next,
  output logic                       p1_wr_next,
  output logic                       p0_rd_valid,
  output logic                       p1_rd_valid,
  output logic                       p0_done,
  output logic                       p1_done,
  output logic [DATA_BITWIDTH-1:0]   rd_data,
  output logic                       br_cmd,
  output logic                       br_cmd_en,
  output logic [ADDR_BITWIDTH-1:0]   br_addr,
  output logic [DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                       br_rd_data_valid,
  input  logic                       br_busy
);

  localparam int CW = $clog2(BURST_COUNT) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_COUNT - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ISSUE = 5'b00010,
    WRITE = 5'b00100,
    READ  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              cmd_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        grant_q;
  logic [1:0]        wr_next_q;
  logic [1:0]        done_q;
  logic              cmd_en_q;
  logic              br_cmd_q;
  logic [ADDR_BITWIDTH-1:0] br_addr_q;

  logic              win;
  logic              sel_cmd;
  logic [ADDR_BITWIDTH-1:0] sel_addr;
  logic [1:0]        win_vec;
  logic [1:0]        own_vec;

`ifdef ARB_ROUND_ROBIN_EN
  // Port favoured on a tie; it flips away from whoever was last issued.
  logic prio_q;

  always_comb begin
    win = ~p0_req;
    if (p0_req && p1_req) win = prio_q;
  end
`else
  always_comb begin
    win = ~p0_req;
  end
`endif

  assign sel_cmd  = win ? p1_cmd : p0_cmd;
  assign sel_addr = win ? p1_addr : p0_addr;
  assign win_vec  = {win, ~win};
  assign own_vec  = {owner_q, ~owner_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      cmd_q     <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= 2'b00;
      wr_next_q <= 2'b00;
      done_q    <= 2'b00;
      cmd_en_q  <= 1'b0;
      br_cmd_q  <= 1'b0;
      br_addr_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!br_busy && (p0_req || p1_req)) begin
            state_q   <= ISSUE;
            owner_q   <= win;
            cmd_q     <= sel_cmd;
            grant_q   <= win_vec;
            cmd_en_q  <= 1'b1;
            br_cmd_q  <= sel_cmd;
            br_addr_q <= sel_addr;
            // first write word goes out alongside the command
            wr_next_q <= sel_cmd ? win_vec : 2'b00;
          end
        end
        ISSUE: begin
          grant_q   <= 2'b00;
          cmd_en_q  <= 1'b0;
          br_cmd_q  <= 1'b0;
          br_addr_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          prio_q    <= ~owner_q;
`endif
          if (cmd_q) begin
            state_q <= WRITE;
            cnt_q   <= CW'(1);
          end else begin
            state_q <= READ;
            cnt_q   <= '0;
          end
        end
        WRITE: begin
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            wr_next_q <= 2'b00;
            done_q    <= own_vec;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        READ: begin
          if (br_rd_data_valid) begin
            if (cnt_q == LAST) begin
              state_q <= DONE;
              done_q  <= own_vec;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic in_read;
  assign in_read = (state_q == READ) && br_rd_data_valid;

  assign p0_grant     = grant_q[0];
  assign p1_grant     = grant_q[1];
  assign p0_wr_next   = wr_next_q[0];
  assign p1_wr_next   = wr_next_q[1];
  assign p0_done      = done_q[0];
  assign p1_done      = done_q[1];
  assign p0_rd_valid  = in_read && !owner_q;
  assign p1_rd_valid  = in_read && owner_q;
  assign rd_data      = br_rd_data;
  assign br_cmd       = br_cmd_q;
  assign br_cmd_en    = cmd_en_q;
  assign br_addr      = br_addr_q;
  assign br_wr_data   = owner_q ? p1_wr_data : p0_wr_data;
  assign br_data_mask = '0;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed bench for burst_ram_arbiter with a small
// behavioural burst RAM model and per-port event monitors.
module tb_burst_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic p0_req = 0, p1_req = 0, p0_cmd = 0, p1_cmd = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wr_data, p1_wr_data;
  logic p0_grant, p1_grant, p0_wr_next, p1_wr_next;
  logic p0_rd_valid, p1_rd_valid, p0_done, p1_done;
  logic [DW-1:0] rd_data, br_wr_data, br_rd_data;
  logic br_cmd, br_cmd_en, br_rd_data_valid;
  logic br_busy = 0;
  logic [AW-1:0] br_addr;
  logic [DW/8-1:0] br_data_mask;

  burst_ram_arbiter #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW),
                      .BURST_COUNT(BC)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p1_req(p1_req),
    .p0_cmd(p0_cmd), .p1_cmd(p1_cmd),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wr_data(p0_wr_data), .p1_wr_data(p1_wr_data),
    .p0_grant(p0_grant), .p1_grant(p1_grant),
    .p0_wr_next(p0_wr_next), .p1_wr_next(p1_wr_next),
    .p0_rd_valid(p0_rd_valid), .p1_rd_valid(p1_rd_valid),
    .p0_done(p0_done), .p1_done(p1_done),
    .rd_data(rd_data),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid),
    .br_busy(br_busy)
  );

  // requester write word sources, advanced on wr_next
  logic [DW-1:0] wb0 [4] = '{64'h5A5A_0000, 64'h5A5A_0001,
                             64'h5A5A_0002, 64'h5A5A_0003};
  logic [DW-1:0] wb1 [4] = '{64'hAAAA_0000_0000_000A,
                             64'hBBBB_0000_0000_000B,
                             64'hCCCC_0000_0000_000C,
                             64'hDDDD_0000_0000_000D};
  logic [1:0] wn0 = 2'd0, wn1 = 2'd0;
  assign p0_wr_data = wb0[wn0];
  assign p1_wr_data = wb1[wn1];

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (p0_wr_next) wn0 <= wn0 + 2'd1;
    if (p1_wr_next) wn1 <= wn1 + 2'd1;
  end

  // burst RAM model: 2-cycle read latency, one bubble mid-burst
  logic [DW-1:0] mem [16];
  logic inited = 1'b0;
  logic [AW-1:0] wptr = '0, rptr = '0;
  int rleft = 0, rdly = 0;
  logic m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic stray = 1'b0;
  assign br_rd_data_valid = m_valid | stray;
  assign br_rd_data = m_data;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (!inited) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h1000 + 64'(i);
      inited <= 1'b1;
    end else if (!rst_n) begin
      rleft <= 0;
    end else begin
      if (br_cmd_en && br_cmd) begin
        mem[br_addr] <= br_wr_data;
        wptr <= br_addr + AW'(1);
      end else if (p0_wr_next || p1_wr_next) begin
        mem[wptr] <= br_wr_data;
        wptr <= wptr + AW'(1);
      end
      if (br_cmd_en && !br_cmd) begin
        rptr  <= br_addr;
        rleft <= BC;
        rdly  <= 2;
      end else if (rleft > 0) begin
        if (rdly > 0) rdly <= rdly - 1;
        else begin
          m_valid <= 1'b1;
          m_data  <= mem[rptr];
          rptr    <= rptr + AW'(1);
          rleft   <= rleft - 1;
          rdly    <= (rleft == 3) ? 1 : 0;
        end
      end
    end
  end

  // event monitors
  int g_cnt [2] = '{0, 0};
  int wn_cnt [2] = '{0, 0};
  int rv_cnt [2] = '{0, 0};
  int d_cnt [2] = '{0, 0};
  int g_cyc [2] = '{0, 0};
  int d_cyc [2] = '{0, 0};
  int rv_cyc [2] = '{0, 0};
  logic [DW-1:0] rq0 [$];
  logic [DW-1:0] rq1 [$];
  int order [$];

  always @(negedge clk) begin
    if (p0_grant) begin
      g_cnt[0]++; g_cyc[0] = cyc; order.push_back(0);
    end
    if (p1_grant) begin
      g_cnt[1]++; g_cyc[1] = cyc; order.push_back(1);
    end
    if (p0_wr_next) wn_cnt[0]++;
    if (p1_wr_next) wn_cnt[1]++;
    if (p0_rd_valid) begin
      rv_cnt[0]++; rv_cyc[0] = cyc; rq0.push_back(rd_data);
    end
    if (p1_rd_valid) begin
      rv_cnt[1]++; rv_cyc[1] = cyc; rq1.push_back(rd_data);
    end
    if (p0_done) begin d_cnt[0]++; d_cyc[0] = cyc; end
    if (p1_done) begin d_cnt[1]++; d_cyc[1] = cyc; end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_grant(input int p, input string tag);
    int n = 0;
    logic g;
    do begin
      @(negedge clk);
      n++;
      g = p ? p1_grant : p0_grant;
    end while (!g && n < 40);
    check(tag, g, 1'b1);
  endtask

  task automatic wait_done(input int p, input string tag);
    int n = 0;
    logic d;
    do begin
      @(negedge clk);
      n++;
      d = p ? p1_done : p0_done;
    end while (!d && n < 60);
    check(tag, d, 1'b1);
    @(negedge clk);
  endtask

  function automatic logic [9:0] ctl();
    return {p0_grant, p1_grant, p0_wr_next, p1_wr_next,
            p0_rd_valid, p1_rd_valid, p0_done, p1_done,
            br_cmd_en, br_cmd};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int b_rv, b_d, b_q, b_wn, b_g, ob;
  logic seen;

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'(ctl()), 64'd0);
    check("rst_addr", 64'(br_addr), 64'd0);
    check("rst_mask", 64'(br_data_mask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // p0 read burst at 4
    b_rv = rv_cnt[0]; b_d = d_cnt[0]; b_q = rq0.size();
    p0_req = 1; p0_cmd = 0; p0_addr = 4;
    @(negedge clk);
    check("rd_grant", 64'(p0_grant), 64'd1);
    check("rd_cmd", 64'({br_cmd_en, br_cmd, br_addr}), 64'h24);
    p0_req = 0;
    wait_done(0, "rd_done_seen");
    check("rd_valid_cnt", 64'(rv_cnt[0] - b_rv), 64'd4);
    check("rd_done_cnt", 64'(d_cnt[0] - b_d), 64'd1);
    check("rd_done_lat", 64'(d_cyc[0] - rv_cyc[0]), 64'd1);
    check("p1_silent", 64'(g_cnt[1] + rv_cnt[1] + d_cnt[1] + wn_cnt[1]), 64'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("rd_data%0d", i), rq0[b_q + i], 64'h1004 + 64'(i));

    // p1 write burst at 8, then read it back
    b_wn = wn_cnt[1];
    p1_req = 1; p1_cmd = 1; p1_addr = 8;
    @(negedge clk);
    check("wr_grant", 64'({p1_grant, p1_wr_next, br_cmd}), 64'h7);
    p1_req = 0;
    wait_done(1, "wr_done_seen");
    check("wr_next_cnt", 64'(wn_cnt[1] - b_wn), 64'd4);
    check("wr_done_lat", 64'(d_cyc[1] - g_cyc[1]), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wr_mem%0d", i), mem[8 + i], wb1[i]);
    b_q = rq1.size();
    p1_req = 1; p1_cmd = 0; p1_addr = 8;
    wait_grant(1, "rb_grant");
    p1_req = 0;
    wait_done(1, "rb_done_seen");
    for (int i = 0; i < 4; i++)
      check($sformatf("rb_data%0d", i), rq1[b_q + i], wb1[i]);

    // simultaneous continuous requests
    ob = order.size();
    p0_req = 1; p0_cmd = 0; p0_addr = 0;
    p1_req = 1; p1_cmd = 0; p1_addr = 4;
    for (int n = 0; n < 200 && order.size() < ob + 4; n++)
      @(negedge clk);
    p0_req = 0; p1_req = 0;
    check("arb_count", 64'(order.size() >= ob + 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("arb_order%0d", i), 64'(order[ob + i]), 64'(i % 2));
`else
      check($sformatf("arb_order%0d", i), 64'(order[ob + i]), 64'd0);
`endif
    end
    repeat (30) @(negedge clk);

    // held off by br_busy
    br_busy = 1;
    p1_req = 1; p1_cmd = 0; p1_addr = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | p0_grant | p1_grant;
    end
    check("busy_nogrant", 64'(seen), 64'd0);
    br_busy = 0;
    @(negedge clk);
    check("busy_grant", 64'(p1_grant), 64'd1);
    p1_req = 0;
    wait_done(1, "busy_done_seen");

    // stray RAM valid while idle
    stray = 1;
    @(negedge clk);
    check("stray_valid", 64'({p0_rd_valid, p1_rd_valid}), 64'd0);
    stray = 0;
    @(negedge clk);

    // reset in the middle of a write burst
    p0_req = 1; p0_cmd = 1; p0_addr = 12;
    wait_grant(0, "abort_grant");
    p0_req = 0;
    @(negedge clk);
    check("abort_in_write", 64'(p0_wr_next), 64'd1);
    b_d = d_cnt[0];
    rst_n = 0;
    @(negedge clk);
    check("abort_ctl", 64'(ctl()), 64'd0);
    rst_n = 1;
    repeat (6) @(negedge clk);
    check("abort_nodone", 64'(d_cnt[0] - b_d), 64'd0);

    // normal read after reset
    b_q = rq0.size(); b_d = d_cnt[0];
    p0_req = 1; p0_cmd = 0; p0_addr = 4;
    wait_grant(0, "post_grant");
    p0_req = 0;
    wait_done(0, "post_done_seen");
    check("post_done_cnt", 64'(d_cnt[0] - b_d), 64'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("post_data%0d", i), rq0[b_q + i], 64'h1004 + 64'(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
